// File: rtl/chunked_add_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// Holds the FSM state enum, the default chunk width and the chunk-count helper.
package chunked_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CHUNK_DEF = 3;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/chunked_add_seq_cla_chunk.sv
// cla_chunk: combinational CHUNK-bit carry-lookahead slice.
// Ports: a, b, cin in; sum out; cout = carry out of the slice MSB.
module cla_chunk #(
  parameter int CHUNK = 3
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK-1:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, fully expanded
  always_comb begin
    logic acc;
    logic term;
    c    = '0;
    acc  = 1'b0;
    term = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      acc = cin;
      for (int j = 0; j <= i; j++)
        acc = acc & p[j];
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++)
          term = term & p[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == 0)
        sum[i] = p[i] ^ cin;
      else
        sum[i] = p[i] ^ c[i-1];
    end
  end

  assign cout = c[CHUNK-1];

endmodule

// File: rtl/chunked_add_seq.sv
// chunked_add_seq: multi-cycle WIDTH-bit adder, one CHUNK-bit slice per cycle.
// Ports: in_valid/in_ready/in_a/in_b/in_cin, out_valid/out_ready/out_sum/out_cout, busy.
// Define CHUNKED_ADD_SUB_EN to add in_sub (A-B when set at accept).
module chunked_add_seq
  import chunked_add_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CHUNKED_ADD_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);

  localparam int NCH = (CHUNK < 1) ? 1 : nchunk(WIDTH, CHUNK);
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("chunked_add_seq: CHUNK must be >= 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("chunked_add_seq: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_reg;

  logic [CHUNK-1:0] s_sum;
  logic             s_cout;

  cla_chunk #(
    .CHUNK(CHUNK)
  ) u_cla (
    .a    (a_reg[idx*CHUNK +: CHUNK]),
    .b    (b_reg[idx*CHUNK +: CHUNK]),
    .cin  (carry),
    .sum  (s_sum),
    .cout (s_cout)
  );

  logic             sub;
`ifdef CHUNKED_ADD_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
      out_cout <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= in_a;
            b_reg <= sub ? ~in_b : in_b;
            carry <= sub ? 1'b1 : in_cin;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[idx*CHUNK +: CHUNK] <= s_sum;
          carry <= s_cout;
          if (idx == LAST) begin
            out_cout <= s_cout;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags decode straight from the state flops.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_sum   = sum_reg;

endmodule

// File: tb/tb_chunked_add_seq.sv
// Directed self-checking bench for chunked_add_seq (WIDTH=12, CHUNK=3).
// Table of add vectors plus hold, back-to-back and reset sequences.
module tb_chunked_add_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_a;
  logic [11:0] in_b;
  logic        in_cin;
`ifdef CHUNKED_ADD_SUB_EN
  logic        in_sub;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        out_cout;
  logic        busy;

  chunked_add_seq #(
    .WIDTH(12),
    .CHUNK(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CHUNKED_ADD_SUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic        cin;
    logic        sub;
    logic [11:0] sum;
    logic        cout;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", n, act, exp);
  endtask

  // Accept one op, measure latency, check result, then hand it off.
  task automatic run_op(input vec_t v, input string n);
    int lat;
    @(negedge clk);
    chk({n, "_in_ready"}, 32'(in_ready), 32'd1);
    in_a     = v.a;
    in_b     = v.b;
    in_cin   = v.cin;
`ifdef CHUNKED_ADD_SUB_EN
    in_sub   = v.sub;
`endif
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({n, "_latency"}, 32'(lat), 32'd4);
    @(negedge clk);
    chk({n, "_sum"}, 32'(out_sum), 32'(v.sum));
    chk({n, "_cout"}, 32'(out_cout), 32'(v.cout));
    chk({n, "_busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({n, "_idle_after"}, 32'({in_ready, out_valid}), 32'b10);
  endtask

  vec_t vt[8];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
`ifdef CHUNKED_ADD_SUB_EN
    in_sub    = 1'b0;
`endif
    out_ready = 1'b0;

    vt[0] = '{12'h0FF, 12'h001, 1'b0, 1'b0, 12'h100, 1'b0};
    vt[1] = '{12'hFFF, 12'h001, 1'b0, 1'b0, 12'h000, 1'b1};
    vt[2] = '{12'h000, 12'h000, 1'b1, 1'b0, 12'h001, 1'b0};
    vt[3] = '{12'h123, 12'h456, 1'b0, 1'b0, 12'h579, 1'b0};
    vt[4] = '{12'h800, 12'h800, 1'b0, 1'b0, 12'h000, 1'b1};
    vt[5] = '{12'hABC, 12'h544, 1'b1, 1'b0, 12'h001, 1'b1};
    vt[6] = '{12'hFFF, 12'hFFF, 1'b1, 1'b0, 12'hFFF, 1'b1};
    vt[7] = '{12'h555, 12'hAAA, 1'b0, 1'b0, 12'hFFF, 1'b0};

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(out_sum), 32'd0);
    chk("rst_cout", 32'(out_cout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Consecutive table ops also exercise accept right after handshake.
    for (int i = 0; i < 8; i++)
      run_op(vt[i], $sformatf("vec%0d", i));

    // Hold in DONE with out_ready low; new operands must be ignored.
    @(negedge clk);
    in_a = 12'h123; in_b = 12'h456; in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_a = 12'h777; in_b = 12'h111; in_cin = 1'b1;
    begin
      int lat;
      lat = 0;
      while (!out_valid && lat < 20) begin
        @(posedge clk);
        #1;
        lat++;
      end
      chk("hold_latency", 32'(lat), 32'd4);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_state", k),
          32'({out_valid, in_ready, busy}), 32'b101);
      chk($sformatf("hold%0d_sum", k), 32'(out_sum), 32'h579);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("hold_release", 32'({in_ready, out_valid}), 32'b10);
    run_op(vt[1], "after_hold");

    // Reset while RUN is on chunk idx=2 (partial sum nonzero).
    @(negedge clk);
    in_a = 12'h555; in_b = 12'hAAA; in_cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flags", 32'({in_ready, out_valid, busy}), 32'b100);
    chk("midrst_sum", 32'(out_sum), 32'd0);
    chk("midrst_cout", 32'(out_cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(in_ready), 32'd1);
    run_op(vt[3], "post_rst");

`ifdef CHUNKED_ADD_SUB_EN
    run_op('{12'h005, 12'h007, 1'b0, 1'b1, 12'hFFE, 1'b0}, "sub0");
    run_op('{12'h007, 12'h005, 1'b0, 1'b1, 12'h002, 1'b1}, "sub1");
    run_op('{12'h007, 12'h005, 1'b1, 1'b0, 12'h00D, 1'b0}, "sub_off");
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
